// File: rtl/dp_demod.sv
// dp_demod: AM/FM demodulator. AM rectifies, FM uses a delay-and-multiply discriminator, then an N-tap moving average.
// Defining DP_DEMOD_DC_BLOCK_EN adds a first-order DC blocker as a fourth output stage.
module dp_demod #(
    parameter int LOG2_N   = 3,
    parameter int D        = 2,
    parameter int DC_SHIFT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] i_data,
    input  logic               val_in,
    input  logic               c_fm_am,
    output logic signed [15:0] o_data,
    output logic               val_out
);
    localparam int N  = 1 << LOG2_N;
    localparam int AW = 16 + LOG2_N;
    localparam logic [7:0] D_C      = 8'(D);
    localparam logic [7:0] N_C      = 8'(N);
    localparam logic [7:0] N_M1_C   = 8'(N - 1);
    localparam logic [7:0] ND_M1_C  = 8'(N + D - 1);
    localparam logic [7:0] CNT_MAX  = 8'hFF;
    localparam logic [LOG2_N-1:0] WP_ONE = LOG2_N'(1);

    if (LOG2_N < 1 || LOG2_N > 6 || D < 1 || D > 15 || DC_SHIFT < 1 || DC_SHIFT > 15) begin : g_param_check
        $error("dp_demod: parameter out of range");
    end

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            sat16 = 16'sh7FFF;
        end else if (v < 32'shFFFF_8000) begin
            sat16 = 16'sh8000;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

    // ---------------- stage 1: warm-up bookkeeping and pre-processing ----------------
    logic               mode_r;
    logic [7:0]         cnt_r;
    logic signed [15:0] dly_r [D];

    logic               mc_s;
    logic [7:0]         cnt_eff_s;
    logic signed [15:0] xd_s;
    logic signed [31:0] prod_s;
    logic signed [31:0] prod_sh_s;
    logic signed [15:0] p_s;
    logic               sup_s;
    logic               ook_s;

    // a sample whose mode differs from the stored one starts a fresh warm-up at index 0
    always_comb begin
        mc_s      = val_in && (c_fm_am != mode_r);
        cnt_eff_s = mc_s ? 8'd0 : cnt_r;
        xd_s      = (cnt_eff_s >= D_C) ? dly_r[D-1] : 16'sd0;
        prod_s    = 32'(i_data) * 32'(xd_s);
        prod_sh_s = prod_s >>> 15;
        if (c_fm_am) begin
            p_s = sat16(prod_sh_s);
        end else if (i_data == 16'sh8000) begin
            p_s = 16'sh7FFF;
        end else if (i_data[15]) begin
            p_s = -i_data;
        end else begin
            p_s = i_data;
        end
        if (c_fm_am) begin
            sup_s = (cnt_eff_s < ND_M1_C);
        end else begin
            sup_s = (cnt_eff_s < N_M1_C);
        end
        ook_s = (cnt_eff_s >= N_C);
    end

    // stored mode and saturating sample counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_r <= 1'b0;
            cnt_r  <= 8'd0;
        end else if (val_in) begin
            mode_r <= c_fm_am;
            cnt_r  <= (cnt_eff_s == CNT_MAX) ? CNT_MAX : cnt_eff_s + 8'd1;
        end
    end

    // sample delay line; contents are never cleared, validity comes from the counter
    always_ff @(posedge clk) begin
        if (rst && val_in) begin
            dly_r[0] <= i_data;
            for (int i = 1; i < D; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    logic               s1_v_r;
    logic               s1_sup_r;
    logic               s1_mc_r;
    logic               s1_ook_r;
    logic signed [15:0] s1_p_r;

    // stage 1 pipeline register
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_v_r   <= 1'b0;
            s1_sup_r <= 1'b1;
            s1_mc_r  <= 1'b0;
            s1_ook_r <= 1'b0;
            s1_p_r   <= 16'sd0;
        end else begin
            s1_v_r <= val_in;
            if (val_in) begin
                s1_sup_r <= sup_s;
                s1_mc_r  <= mc_s;
                s1_ook_r <= ook_s;
                s1_p_r   <= p_s;
            end
        end
    end

    // ---------------- stage 2: moving-average accumulator ----------------
    logic signed [15:0]   pbuf_r [N];
    logic [LOG2_N-1:0]    wp_r;
    logic signed [AW-1:0] acc_r;
    logic signed [AW-1:0] acc_nxt_s;
    logic signed [15:0]   p_old_s;
    logic                 s2_v_r;
    logic                 s2_sup_r;
`ifdef DP_DEMOD_DC_BLOCK_EN
    logic                 s2_mc_r;
`endif

    // the slot about to be overwritten holds the value leaving the window once N entries exist
    always_comb begin
        p_old_s = s1_ook_r ? pbuf_r[wp_r] : 16'sd0;
        if (s1_mc_r) begin
            acc_nxt_s = AW'(s1_p_r);
        end else begin
            acc_nxt_s = acc_r + AW'(s1_p_r) - AW'(p_old_s);
        end
    end

    // accumulator, write pointer and stage 2 valid/flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_r     <= {LOG2_N{1'b0}};
            acc_r    <= {AW{1'b0}};
            s2_v_r   <= 1'b0;
            s2_sup_r <= 1'b1;
`ifdef DP_DEMOD_DC_BLOCK_EN
            s2_mc_r  <= 1'b0;
`endif
        end else begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                wp_r     <= wp_r + WP_ONE;
                acc_r    <= acc_nxt_s;
                s2_sup_r <= s1_sup_r;
`ifdef DP_DEMOD_DC_BLOCK_EN
                s2_mc_r  <= s1_mc_r;
`endif
            end
        end
    end

    // circular window buffer, written on every valid sample
    always_ff @(posedge clk) begin
        if (rst && s1_v_r) begin
            pbuf_r[wp_r] <= s1_p_r;
        end
    end

    // ---------------- stage 3 (and optional stage 4): output ----------------
    logic signed [15:0] avg_s;

    // window mean with floor rounding
    always_comb begin
        avg_s = 16'(acc_r >>> LOG2_N);
    end

`ifdef DP_DEMOD_DC_BLOCK_EN
    localparam int DW = 16 + DC_SHIFT;

    logic                 s3_v_r;
    logic                 s3_sup_r;
    logic                 s3_mc_r;
    logic signed [15:0]   s3_avg_r;
    logic signed [DW-1:0] dc_acc_r;
    logic signed [15:0]   dc_s;
    logic signed [16:0]   diff_s;

    // stage 3 register holding the average ahead of the DC blocker
    always_ff @(posedge clk) begin
        if (!rst) begin
            s3_v_r   <= 1'b0;
            s3_sup_r <= 1'b1;
            s3_mc_r  <= 1'b0;
            s3_avg_r <= 16'sd0;
        end else begin
            s3_v_r <= s2_v_r;
            if (s2_v_r) begin
                s3_sup_r <= s2_sup_r;
                s3_mc_r  <= s2_mc_r;
                s3_avg_r <= avg_s;
            end
        end
    end

    // DC estimate and the high-passed difference
    always_comb begin
        dc_s   = 16'(dc_acc_r >>> DC_SHIFT);
        diff_s = 17'(s3_avg_r) - 17'(dc_s);
    end

    // DC blocker state and registered outputs; the new mode's first sample clears the estimate
    always_ff @(posedge clk) begin
        if (!rst) begin
            dc_acc_r <= {DW{1'b0}};
            o_data   <= 16'sd0;
            val_out  <= 1'b0;
        end else begin
            val_out <= s3_v_r && !s3_sup_r;
            if (s3_v_r && s3_mc_r) begin
                dc_acc_r <= {DW{1'b0}};
            end else if (s3_v_r && !s3_sup_r) begin
                dc_acc_r <= dc_acc_r + DW'(diff_s);
                o_data   <= sat16(32'(diff_s));
            end
        end
    end
`else
    // registered outputs; o_data holds between emitted samples
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_data  <= 16'sd0;
            val_out <= 1'b0;
        end else begin
            val_out <= s2_v_r && !s2_sup_r;
            if (s2_v_r && !s2_sup_r) begin
                o_data <= avg_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dp_demod.sv
// Directed bench for dp_demod: a queue-based reference model checked every cycle,
// plus literal expectations on captured outputs for the documented scenarios.
module tb_dp_demod;
    localparam int LOG2_N   = 3;
    localparam int N        = 8;
    localparam int D        = 2;
    localparam int DC_SHIFT = 8;
`ifdef DP_DEMOD_DC_BLOCK_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic               clk     = 1'b0;
    logic               rst     = 1'b0;
    logic               val_in  = 1'b0;
    logic               c_fm_am = 1'b0;
    logic signed [15:0] i_data  = 16'sd0;
    logic signed [15:0] o_data;
    logic               val_out;

    dp_demod #(.LOG2_N(LOG2_N), .D(D), .DC_SHIFT(DC_SHIFT)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .val_in  (val_in),
        .c_fm_am (c_fm_am),
        .o_data  (o_data),
        .val_out (val_out)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    int     edge_cnt = 0;
    int     seg_x[$];
    int     seg_p[$];
    int     pend_due[$];
    int     pend_val[$];
    bit     st_mode = 1'b0;
    longint dc_acc = 0;
    int     hold = 0;
    int     n_out = 0;
    int     last_out = 0;
    int     first_out_edge = -1;
    int     first_in = 0;
    int     outs[4];

    function automatic longint fdiv(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clamp16(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic model_reset();
        seg_x.delete();
        seg_p.delete();
        pend_due.delete();
        pend_val.delete();
        st_mode = 1'b0;
        dc_acc = 0;
        hold = 0;
    endtask

    // reference: per-mode segment of samples; output = floor mean of last N rectified/discriminated values
    task automatic model_in(bit m, int x, int sedge);
        int n, xd, p, avg, outv;
        longint sum, dcv, diff;
        if (m != st_mode) begin
            seg_x.delete();
            seg_p.delete();
            dc_acc = 0;
        end
        st_mode = m;
        n = seg_x.size();
        xd = (n >= D) ? seg_x[n-D] : 0;
        if (m) p = clamp16(fdiv(longint'(x) * longint'(xd), 32768));
        else   p = (x < 0) ? clamp16(-longint'(x)) : x;
        seg_x.push_back(x);
        seg_p.push_back(p);
        sum = 0;
        for (int k = 0; k < N; k++) if (n - k >= 0) sum += seg_p[n-k];
        avg = int'(fdiv(sum, N));
        outv = avg;
`ifdef DP_DEMOD_DC_BLOCK_EN
        if (n + 1 >= (m ? N + D : N)) begin
            dcv = fdiv(dc_acc, longint'(1) << DC_SHIFT);
            diff = longint'(avg) - dcv;
            outv = clamp16(diff);
            dc_acc = dc_acc + diff;
        end
`else
        dcv = 0;
        diff = dcv;
`endif
        if (n + 1 >= (m ? N + D : N)) begin
            pend_due.push_back(sedge + LAT - 1);
            pend_val.push_back(outv);
        end
    endtask

    task automatic check();
        int exp_v, exp_d, od, ov;
        if (pend_due.size() > 0 && pend_due[0] == edge_cnt) begin
            exp_v = 1;
            exp_d = pend_val[0];
            void'(pend_due.pop_front());
            void'(pend_val.pop_front());
            hold = exp_d;
        end else begin
            exp_v = 0;
            exp_d = hold;
        end
        od = o_data;
        ov = int'(val_out);
        total++;
        if (ov != exp_v || od != exp_d) begin
            bad++;
            $display("FAIL cycle_check edge=%0d: got val_out=%0d o_data=%0d, expected val_out=%0d o_data=%0d",
                     edge_cnt, ov, od, exp_v, exp_d);
        end
        if (ov == 1) begin
            if (n_out < 4) outs[n_out] = od;
            if (first_out_edge < 0) first_out_edge = edge_cnt;
            n_out++;
            last_out = od;
        end
    endtask

    task automatic lit(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(bit r, bit v, bit m, int x);
        @(negedge clk);
        rst = r;
        val_in = v;
        c_fm_am = m;
        i_data = 16'(x);
        if (!r) model_reset();
        else if (v) model_in(m, x, edge_cnt + 1);
        @(posedge clk);
        edge_cnt++;
        #1;
        check();
    endtask

    task automatic run(int n, bit m, int x);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, m, x);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        lit("reset_val_out", int'(val_out), 0);
        lit("reset_o_data", int'(o_data), 0);

        // AM constant 1000 warm-up and latency, then straight into FM (mode change with AM in flight)
        n_out = 0;
        first_out_edge = -1;
        first_in = edge_cnt + 1;
        run(20, 1'b0, 1000);
        lit("am_latency", first_out_edge - first_in, 7 + LAT - 1);
`ifdef DP_DEMOD_DC_BLOCK_EN
        lit("dc_out0", outs[0], 1000);
        lit("dc_out1", outs[1], 997);
        lit("dc_out2", outs[2], 993);
`else
        lit("am_first", outs[0], 1000);
`endif
        run(20, 1'b1, 16384);
        idle(6);
        lit("mode_change_count", n_out, 24);
`ifndef DP_DEMOD_DC_BLOCK_EN
        lit("fm_const", last_out, 8192);
`endif

        // FM period-4 pattern
        n_out = 0;
        for (int r = 0; r < 6; r++) begin
            run(1, 1'b1, 0);
            run(1, 1'b1, 16384);
            run(1, 1'b1, 0);
            run(1, 1'b1, -16384);
        end
        idle(4);
        lit("fm_alt_count", n_out, 24);
`ifndef DP_DEMOD_DC_BLOCK_EN
        lit("fm_alt", last_out, -4096);
`endif

        // AM saturation and negative input
        n_out = 0;
        run(10, 1'b0, -32768);
        idle(4);
        lit("am_sat_count", n_out, 3);
`ifndef DP_DEMOD_DC_BLOCK_EN
        lit("am_sat", last_out, 32767);
`endif
        n_out = 0;
        run(10, 1'b0, -5);
        idle(4);
        lit("am_neg_count", n_out, 10);
`ifndef DP_DEMOD_DC_BLOCK_EN
        lit("am_neg", last_out, 5);
`endif

        // gapped input 1,0,0,1 after a reset
        step(1'b0, 1'b0, 1'b0, 0);
        n_out = 0;
        for (int r = 0; r < 10; r++) begin
            step(1'b1, 1'b1, 1'b0, 1000);
            step(1'b1, 1'b0, 1'b0, 0);
            step(1'b1, 1'b0, 1'b0, 0);
            step(1'b1, 1'b1, 1'b0, 1000);
        end
        idle(4);
        lit("gap_count", n_out, 13);
`ifndef DP_DEMOD_DC_BLOCK_EN
        lit("gap_val", last_out, 1000);
`endif

        // back-to-back mode changes: every sample restarts warm-up
        n_out = 0;
        for (int r = 0; r < 4; r++) begin
            step(1'b1, 1'b1, 1'b1, 1000);
            step(1'b1, 1'b1, 1'b0, 1000);
        end
        idle(4);
        lit("alt_mode_count", n_out, 0);

        // reset during FM streaming
        run(15, 1'b1, 16384);
        lit("pre_reset_val_out", int'(val_out), 1);
        step(1'b0, 1'b1, 1'b1, 16384);
        lit("mid_reset_val_out", int'(val_out), 0);
        lit("mid_reset_o_data", int'(o_data), 0);
        n_out = 0;
        run(12, 1'b1, 16384);
        idle(5);
        lit("restart_count", n_out, 3);
`ifndef DP_DEMOD_DC_BLOCK_EN
        lit("restart_val", last_out, 8192);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
